// File: rtl/mic_capture_ctrl.sv
// PDM microphone capture sequencer: divides clk down to mclk, waits out mic start-up,
// then packs micData into 16-bit words written to consecutive sample-RAM addresses.
module mic_capture_ctrl #(
  parameter int CLK_DIV = 32,
  parameter int WARMUP  = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              micData_i,
  output logic              mclk_o,
  output logic              micLRSel_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   words_o
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int WRM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [WRM_W-1:0]  WRM_LAST  = WRM_W'(WARMUP - 1);
  localparam logic [ADDR_W-1:0] WPTR_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CAPTURE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [WRM_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [14:0]         sreg_q, sreg_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                mclk_q, mclk_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;

  logic run_q, run_d, strobe, word_done, idle_like;

  assign run_q     = (state_q == S_WARMUP) || (state_q == S_CAPTURE);
  assign run_d     = (state_d == S_WARMUP) || (state_d == S_CAPTURE);
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  // Strobe is the last high-phase clk of each mclk period, just before mclk falls.
  assign strobe    = run_q && (div_cnt_q == DIV_LAST);
  assign word_done = (state_q == S_CAPTURE) && strobe && (bit_cnt_q == 4'd15);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_WARMUP;
      S_WARMUP: begin
        if (stop_i)                                state_d = S_DONE;
        else if (strobe && warm_cnt_q == WRM_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: if (stop_i || (word_done && wptr_q == WPTR_LAST)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = run_q;
    done_o = (state_q == S_DONE);
  end

  always_comb begin
    div_cnt_d   = '0;
    warm_cnt_d  = warm_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sreg_d      = sreg_q;
    wptr_d      = wptr_q;
    words_d     = words_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (run_q && run_d) div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    // mclk derives from the next divider value so both flops move together.
    mclk_d = (div_cnt_d >= DIV_HALF);
    if (state_q == S_WARMUP && strobe) warm_cnt_d = warm_cnt_q + 1'b1;
    if (state_q == S_CAPTURE && strobe) begin
      sreg_d    = {sreg_q[13:0], micData_i};
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (word_done) begin
        mem_we_d    = 1'b1;
        mem_wdata_d = {sreg_q, micData_i};
        mem_addr_d  = wptr_q;
        words_d     = words_q + 1'b1;
        if (wptr_q != WPTR_LAST) wptr_d = wptr_q + 1'b1;
      end
    end
    if (state_d == S_DONE) bit_cnt_d = '0;
    if (idle_like && start_i) begin
      words_d    = '0;
      wptr_d     = '0;
      warm_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt_q   <= '0;
      warm_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      sreg_q      <= '0;
      wptr_q      <= '0;
      words_q     <= '0;
      mclk_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sreg_q      <= sreg_d;
      wptr_q      <= wptr_d;
      words_q     <= words_d;
      mclk_q      <= mclk_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mclk_o      = mclk_q;
  assign micLRSel_o  = 1'b0;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign words_o     = words_q;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl at CLK_DIV=4, WARMUP=2, ADDR_W=2:
// a cycle table for divider/FSM control, then hand-timed recording sequences.
module tb_mic_capture_ctrl;
  localparam int ADDR_W = 2;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, mic = 1'b0;
  logic mclk, lrsel, we, busy, done;
  logic [ADDR_W-1:0] addr;
  logic [15:0] wdata;
  logic [ADDR_W:0] words;

  int checks = 0, errors = 0;
  logic [ADDR_W+15:0] wr_q[$];

  mic_capture_ctrl #(.CLK_DIV(4), .WARMUP(2), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop), .micData_i(mic),
    .mclk_o(mclk), .micLRSel_o(lrsel), .mem_we_o(we), .mem_addr_o(addr),
    .mem_wdata_o(wdata), .busy_o(busy), .done_o(done), .words_o(words));

  always #5 clk = ~clk;

  typedef struct packed { logic start, stop, mclk, busy, done; } vec_t;
  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (we === 1'b1) wr_q.push_back({addr, wdata});
  endtask

  // Leaves the bench at the first CAPTURE cycle (divider phase 0).
  task automatic start_rec();
    start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
  endtask

  // One mclk period per bit; pulse 1 = start on a non-strobe cycle, 2 = stop on the strobe cycle.
  task automatic send_bit(input logic b, input int pulse);
    for (int c = 0; c < 4; c++) begin
      mic   = b;
      start = (pulse == 1 && c == 0);
      stop  = (pulse == 2 && c == 3);
      step();
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int start_at, input int stop_at);
    for (int b = 15; b >= 0; b--)
      send_bit(w[b], (b == start_at) ? 1 : (b == stop_at) ? 2 : 0);
  endtask

  initial begin
    vecs[0]  = '{1,0,0,1,0}; vecs[1]  = '{0,0,0,1,0}; vecs[2]  = '{0,0,1,1,0};
    vecs[3]  = '{0,0,1,1,0}; vecs[4]  = '{0,0,0,1,0}; vecs[5]  = '{1,0,0,1,0};
    vecs[6]  = '{0,0,1,1,0}; vecs[7]  = '{0,0,1,1,0}; vecs[8]  = '{0,0,0,1,0};
    vecs[9]  = '{0,0,0,1,0}; vecs[10] = '{0,0,1,1,0}; vecs[11] = '{0,0,1,1,0};
    vecs[12] = '{0,1,0,0,1}; vecs[13] = '{0,1,0,0,1}; vecs[14] = '{1,0,0,1,0};
    vecs[15] = '{0,0,0,1,0}; vecs[16] = '{0,0,1,1,0}; vecs[17] = '{0,1,0,0,1};

    // 1: reset and idle
    repeat (3) step();
    check("rst_mclk", mclk, 0); check("rst_we", we, 0); check("rst_busy", busy, 0);
    check("rst_done", done, 0); check("rst_words", words, 0); check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0); check("rst_lrsel", lrsel, 0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_outs", {mclk, we, busy, done, words}, 0);
    end

    // 2: divider pattern, start ignored while busy, stop in capture/done/warmup
    for (int i = 0; i < 18; i++) begin
      start = vecs[i].start; stop = vecs[i].stop; mic = 1'b0;
      step();
      check($sformatf("vec%0d_mclk", i), mclk, vecs[i].mclk);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_done", i), done, vecs[i].done);
      check($sformatf("vec%0d_we", i), we, 0);
      check($sformatf("vec%0d_lrsel", i), lrsel, 0);
    end
    start = 1'b0; stop = 1'b0;
    check("vec_words", words, 0);

    // 3: word assembly with an ignored start mid-word
    wr_q.delete();
    start_rec();
    check("w3_busy", busy, 1);
    send_word(16'hA5C3, 8, -1);
    check("w3_we", we, 1); check("w3_addr", addr, 0);
    check("w3_wdata", wdata, 16'hA5C3); check("w3_words", words, 1);
    step();
    check("w3_we_drop", we, 0);
    check("w3_nwr", wr_q.size(), 1);
    stop = 1'b1; step(); stop = 1'b0;
    check("w3_done", done, 1); check("w3_busy_end", busy, 0); check("w3_words_end", words, 1);

    // 4: full buffer
    wr_q.delete();
    start_rec();
    check("f4_words0", words, 0);
    send_word(16'h1111, -1, -1); send_word(16'h2222, -1, -1);
    send_word(16'h3333, -1, -1); send_word(16'h4444, -1, -1);
    check("f4_we", we, 1); check("f4_addr", addr, 3); check("f4_wdata", wdata, 16'h4444);
    check("f4_done", done, 1); check("f4_busy", busy, 0);
    check("f4_words", words, 4); check("f4_mclk", mclk, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("f4_hold", {mclk, we, busy, done}, 1);
    end
    check("f4_words_hold", words, 4);
    check("f4_nwr", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++)
      check($sformatf("f4_wr%0d", i), wr_q[i], {i[ADDR_W-1:0], {4{i[3:0] + 4'd1}}});

    // 5: stop with partial word, then stop coinciding with a word's final strobe
    wr_q.delete();
    start_rec();
    send_word(16'h1234, -1, -1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    stop = 1'b1; step(); stop = 1'b0;
    check("s5_done", done, 1); check("s5_busy", busy, 0); check("s5_words", words, 1);
    repeat (8) step();
    check("s5_nwr", wr_q.size(), 1);
    if (wr_q.size() > 0) check("s5_wr0", wr_q[0], {2'd0, 16'h1234});
    wr_q.delete();
    start_rec();
    check("s5_words_clr", words, 0);
    send_word(16'hBEEF, -1, 0);
    check("s5b_we", we, 1); check("s5b_addr", addr, 0); check("s5b_wdata", wdata, 16'hBEEF);
    check("s5b_done", done, 1); check("s5b_words", words, 1);
    step();
    check("s5b_we_drop", we, 0);

    // 6: reset mid-capture, start coinciding with reset
    start_rec();
    for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
    wr_q.delete();
    reset = 1'b1; start = 1'b1; step();
    check("r6_mclk", mclk, 0); check("r6_we", we, 0); check("r6_busy", busy, 0);
    check("r6_done", done, 0); check("r6_words", words, 0); check("r6_addr", addr, 0);
    check("r6_wdata", wdata, 0);
    reset = 1'b0; start = 1'b0;
    repeat (40) step();
    check("r6_idle", {mclk, busy, done}, 0);
    check("r6_nwr", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
